video_timing_gen: RTL and testbench

//  Generates the raster timing for the Jailbreak core: pixel-clock enable, PH/PV beam counters,

---
 rtl/video_timing_gen.sv | 120 ++++++++++++
 tb/tb_video_timing_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-clock enable, PH/PV beam counters, blanking,
// sync windows with per-frame offsets, frame-start strobe and frame counter.
module video_timing_gen #(
    parameter int CLKDIV   = 8,
    parameter int HTOTAL   = 384,
    parameter int HACT     = 256,
    parameter int HS_START = 296,
    parameter int HS_WIDTH = 32,
    parameter int VTOTAL   = 264,
    parameter int VACT_S   = 16,
    parameter int VACT_E   = 240,
    parameter int VS_START = 248,
    parameter int VS_WIDTH = 8
) (
    input  logic       CPUCL,
    input  logic       RESET_N,
    input  logic [3:0] HOFS,
    input  logic [3:0] VOFS,
    output logic       PCLK_EN,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic       HBLK,
    output logic       VBLK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       FRAME_ST,
    output logic [7:0] FCNT
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [DW-1:0] div_reg;
    logic [3:0]    hofs_reg;
    logic [3:0]    vofs_reg;

    logic       adv;
    logic       line_end;
    logic       frame_end;
    logic [8:0] ph_next;
    logic [8:0] pv_next;
    logic [3:0] hofs_next;
    logic [3:0] vofs_next;
    logic [9:0] hs_start;
    logic [9:0] hs_end;
    logic [9:0] vs_start;
    logic [9:0] vs_end;
    logic       hblk_next;
    logic       vblk_next;
    logic       hsync_next;
    logic       vsync_next;

    assign adv       = (div_reg == DW'(CLKDIV - 1));
    assign line_end  = (PH == 9'(HTOTAL - 1));
    assign frame_end = line_end && (PV == 9'(VTOTAL - 1));

    // Next-state beam position and offsets; decoders below look at these so the
    // registered strobes line up with PH/PV on the same edge.
    always_comb begin
        ph_next   = PH;
        pv_next   = PV;
        hofs_next = hofs_reg;
        vofs_next = vofs_reg;
        if (adv) begin
            if (line_end) begin
                ph_next = 9'd0;
                pv_next = (PV == 9'(VTOTAL - 1)) ? 9'd0 : PV + 9'd1;
            end else begin
                ph_next = PH + 9'd1;
            end
            if (frame_end) begin
                hofs_next = HOFS;
                vofs_next = VOFS;
            end
        end
    end

    always_comb begin
        hs_start   = 10'(HS_START) + {{6{hofs_next[3]}}, hofs_next};
        hs_end     = hs_start + 10'(HS_WIDTH);
        vs_start   = 10'(VS_START) + {{6{vofs_next[3]}}, vofs_next};
        vs_end     = vs_start + 10'(VS_WIDTH);
        hblk_next  = (ph_next >= 9'(HACT));
        vblk_next  = (pv_next < 9'(VACT_S)) || (pv_next >= 9'(VACT_E));
        hsync_next = ({1'b0, ph_next} >= hs_start) && ({1'b0, ph_next} < hs_end);
        vsync_next = ({1'b0, pv_next} >= vs_start) && ({1'b0, pv_next} < vs_end);
    end

    always_ff @(posedge CPUCL or negedge RESET_N) begin
        if (!RESET_N) begin
            div_reg  <= '0;
            hofs_reg <= 4'd0;
            vofs_reg <= 4'd0;
            PCLK_EN  <= 1'b0;
            PH       <= 9'd0;
            PV       <= 9'd0;
            HBLK     <= 1'b0;
            VBLK     <= 1'b1;
            HSYNC    <= 1'b0;
            VSYNC    <= 1'b0;
            FRAME_ST <= 1'b0;
            FCNT     <= 8'd0;
        end else begin
            div_reg  <= adv ? '0 : div_reg + 1'b1;
            PCLK_EN  <= adv;
            PH       <= ph_next;
            PV       <= pv_next;
            hofs_reg <= hofs_next;
            vofs_reg <= vofs_next;
            HBLK     <= hblk_next;
            VBLK     <= vblk_next;
            HSYNC    <= hsync_next;
            VSYNC    <= vsync_next;
            FRAME_ST <= adv && frame_end;
            if (adv && frame_end) begin
                FCNT <= FCNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: arithmetic beam model checked every cycle, plus
// literal checkpoints and an asynchronous mid-frame reset.
module tb_video_timing_gen;

    localparam int CLKDIV   = 2;
    localparam int HTOTAL   = 384;
    localparam int HACT     = 256;
    localparam int HS_START = 296;
    localparam int HS_WIDTH = 32;
    localparam int VTOTAL   = 16;
    localparam int VACT_S   = 2;
    localparam int VACT_E   = 8;
    localparam int VS_START = 8;
    localparam int VS_WIDTH = 2;

    logic       CPUCL = 1'b0;
    logic       RESET_N;
    logic [3:0] HOFS;
    logic [3:0] VOFS;
    logic       PCLK_EN;
    logic [8:0] PH;
    logic [8:0] PV;
    logic       HBLK;
    logic       VBLK;
    logic       HSYNC;
    logic       VSYNC;
    logic       FRAME_ST;
    logic [7:0] FCNT;

    video_timing_gen #(
        .CLKDIV(CLKDIV), .HTOTAL(HTOTAL), .HACT(HACT), .HS_START(HS_START),
        .HS_WIDTH(HS_WIDTH), .VTOTAL(VTOTAL), .VACT_S(VACT_S), .VACT_E(VACT_E),
        .VS_START(VS_START), .VS_WIDTH(VS_WIDTH)
    ) dut (
        .CPUCL(CPUCL), .RESET_N(RESET_N), .HOFS(HOFS), .VOFS(VOFS),
        .PCLK_EN(PCLK_EN), .PH(PH), .PV(PV), .HBLK(HBLK), .VBLK(VBLK),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .FRAME_ST(FRAME_ST), .FCNT(FCNT)
    );

    always #5 CPUCL = ~CPUCL;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp, input int when);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0d, expected %0d", name, when, act, exp);
        end
    endtask

    // Literal checkpoints for the first run after reset (t = edges since release).
    typedef struct { int t; int sig; int val; } lit_t;
    // sig: 0 PCLK_EN 1 PH 2 PV 3 HBLK 4 VBLK 5 HSYNC 6 VSYNC 7 FRAME_ST 8 FCNT
    lit_t lits[$];

    function automatic int dut_sig(input int sig);
        case (sig)
            0: return int'(PCLK_EN);
            1: return int'(PH);
            2: return int'(PV);
            3: return int'(HBLK);
            4: return int'(VBLK);
            5: return int'(HSYNC);
            6: return int'(VSYNC);
            7: return int'(FRAME_ST);
            default: return int'(FCNT);
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            0: return "lit_pclk_en";
            1: return "lit_ph";
            2: return "lit_pv";
            3: return "lit_hblk";
            4: return "lit_vblk";
            5: return "lit_hsync";
            6: return "lit_vsync";
            7: return "lit_frame_st";
            default: return "lit_fcnt";
        endcase
    endfunction

    // Model state: only the edge count and the latched offsets.
    int t = 0;
    int run = 0;
    bit was_reset = 1'b1;
    logic signed [3:0] m_hofs = 4'sd0;
    logic signed [3:0] m_vofs = 4'sd0;

    always @(posedge CPUCL) begin
        int pix, ph_e, line_n, pv_e, frame_n, hs, vs;
        bit pclk_e, fs_e;
        #1;
        if (!RESET_N) begin
            t = 0;
            m_hofs = 4'sd0;
            m_vofs = 4'sd0;
            was_reset = 1'b1;
            chk("rst_ph", int'(PH), 0, t);
            chk("rst_pv", int'(PV), 0, t);
            chk("rst_vblk", int'(VBLK), 1, t);
            chk("rst_pclk_en", int'(PCLK_EN), 0, t);
            chk("rst_fcnt", int'(FCNT), 0, t);
        end else begin
            if (was_reset) begin
                run++;
                was_reset = 1'b0;
            end
            t++;
            pix     = t / CLKDIV;
            ph_e    = pix % HTOTAL;
            line_n  = pix / HTOTAL;
            pv_e    = line_n % VTOTAL;
            frame_n = line_n / VTOTAL;
            pclk_e  = (t % CLKDIV) == 0;
            fs_e    = pclk_e && ph_e == 0 && pv_e == 0;
            if (fs_e) begin
                m_hofs = HOFS;
                m_vofs = VOFS;
            end
            hs = HS_START + int'(m_hofs);
            vs = VS_START + int'(m_vofs);
            chk("pclk_en", int'(PCLK_EN), int'(pclk_e), t);
            chk("ph", int'(PH), ph_e, t);
            chk("pv", int'(PV), pv_e, t);
            chk("hblk", int'(HBLK), int'(ph_e >= HACT), t);
            chk("vblk", int'(VBLK), int'(pv_e < VACT_S || pv_e >= VACT_E), t);
            chk("hsync", int'(HSYNC), int'(ph_e >= hs && ph_e < hs + HS_WIDTH), t);
            chk("vsync", int'(VSYNC), int'(pv_e >= vs && pv_e < vs + VS_WIDTH), t);
            chk("frame_st", int'(FRAME_ST), int'(fs_e), t);
            chk("fcnt", int'(FCNT), frame_n % 256, t);
            if (run == 1) begin
                foreach (lits[i]) begin
                    if (lits[i].t == t)
                        chk(sig_name(lits[i].sig), dut_sig(lits[i].sig), lits[i].val, t);
                end
            end
            $display("t=%0d PH=%0d PV=%0d PCLK_EN=%0b FRAME_ST=%0b FCNT=%0d", t, PH, PV, PCLK_EN, FRAME_ST, FCNT);
        end
    end

    task automatic run_to(input int target);
        while (t < target) @(negedge CPUCL);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        // First pixel strobe two edges after release, PH 0->1 with it.
        lits.push_back('{1, 0, 0});
        lits.push_back('{2, 0, 1});
        lits.push_back('{2, 1, 1});
        // HBLK rises at PH 256, HSYNC window 296..327 with zero offset.
        lits.push_back('{510, 3, 0});
        lits.push_back('{512, 3, 1});
        lits.push_back('{590, 5, 0});
        lits.push_back('{592, 5, 1});
        lits.push_back('{654, 5, 1});
        lits.push_back('{656, 5, 0});
        // VBLK falls at PV 2.
        lits.push_back('{1534, 4, 1});
        lits.push_back('{1536, 4, 0});
        // HOFS changed at t=3000: still 296 this frame.
        lits.push_back('{4426, 5, 0});
        lits.push_back('{4432, 5, 1});
        // Line wrap PH 383 PV 5 -> PH 0 PV 6, HBLK falls.
        lits.push_back('{4606, 1, 383});
        lits.push_back('{4606, 3, 1});
        lits.push_back('{4608, 1, 0});
        lits.push_back('{4608, 2, 6});
        lits.push_back('{4608, 3, 0});
        // VSYNC PV 8..9 and VBLK rise at PV 8 in frame 0.
        lits.push_back('{6142, 6, 0});
        lits.push_back('{6144, 6, 1});
        lits.push_back('{6142, 4, 0});
        lits.push_back('{6144, 4, 1});
        lits.push_back('{7680, 6, 0});
        // Frame start.
        lits.push_back('{12286, 2, 15});
        lits.push_back('{12288, 2, 0});
        lits.push_back('{12288, 7, 1});
        lits.push_back('{12288, 8, 1});
        lits.push_back('{12289, 7, 0});
        // Frame 1: HSYNC 293..324 from line 0.
        lits.push_back('{12872, 5, 0});
        lits.push_back('{12874, 5, 1});
        lits.push_back('{12936, 5, 1});
        lits.push_back('{12938, 5, 0});
        // Frame 1: VSYNC with VOFS=+7 starts at PV 15.
        lits.push_back('{23806, 6, 0});
        lits.push_back('{23808, 6, 1});
        lits.push_back('{24576, 8, 2});
        lits.push_back('{24576, 7, 1});

        RESET_N = 1'b0;
        HOFS = 4'h0;
        VOFS = 4'h0;
        repeat (3) @(negedge CPUCL);
        RESET_N = 1'b1;
        run_to(3000);
        HOFS = 4'hD;
        VOFS = 4'h7;
        run_to((2 * HTOTAL * VTOTAL + 10 * HTOTAL + 150) * CLKDIV + 1);
        @(posedge CPUCL);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_ph", int'(PH), 0, t);
        chk("async_pv", int'(PV), 0, t);
        chk("async_hblk", int'(HBLK), 0, t);
        chk("async_vblk", int'(VBLK), 1, t);
        chk("async_hsync", int'(HSYNC), 0, t);
        chk("async_vsync", int'(VSYNC), 0, t);
        chk("async_frame_st", int'(FRAME_ST), 0, t);
        chk("async_fcnt", int'(FCNT), 0, t);
        chk("async_pclk_en", int'(PCLK_EN), 0, t);
        repeat (2) @(negedge CPUCL);
        RESET_N = 1'b1;
        run_to(800);
        @(negedge CPUCL);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
